// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: hc/vc counters, sync, active, coords.
// Ports: clk, rst, px_en in; hsync, vsync, activevideo, x_px, y_px,
//        line_start, frame_start, frame_cnt out (all registered).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10,
  parameter int FW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          px_en,
  output logic          hsync,
  output logic          vsync,
  output logic          activevideo,
  output logic [CW-1:0] x_px,
  output logic [CW-1:0] y_px,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC;

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic [FW-1:0] fc_q, fc_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          av_q, av_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic          hs_in, vs_in;

  // Outputs are decoded from the next position so they land on the
  // same edge as the counters; with px_en low everything holds.
  always_comb begin
    hc_d  = hc_q;
    vc_d  = vc_q;
    fc_d  = fc_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    av_d  = av_q;
    x_d   = x_q;
    y_d   = y_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    hs_in = 1'b0;
    vs_in = 1'b0;
    if (px_en) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == V_LAST) begin
          vc_d = '0;
          fc_d = fc_q + FW'(1);
        end else begin
          vc_d = vc_q + CW'(1);
        end
      end else begin
        hc_d = hc_q + CW'(1);
      end
      hs_in = (int'(hc_d) >= HS_LO) && (int'(hc_d) < HS_HI);
      vs_in = (int'(vc_d) >= VS_LO) && (int'(vc_d) < VS_HI);
      hs_d  = hs_in ? H_POL : ~H_POL;
      vs_d  = vs_in ? V_POL : ~V_POL;
      av_d  = (int'(hc_d) < H_ACTIVE) && (int'(vc_d) < V_ACTIVE);
      x_d   = av_d ? hc_d : '0;
      y_d   = av_d ? vc_d : '0;
      ls_d  = (hc_d == '0);
      fs_d  = (hc_d == '0) && (vc_d == '0);
    end
  end

  // Reset parks at the last position so the first advance wraps to (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q <= H_LAST;
      vc_q <= V_LAST;
      fc_q <= '1;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      av_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      fc_q <= fc_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      av_q <= av_d;
      x_q  <= x_d;
      y_q  <= y_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign activevideo = av_q;
  assign x_px        = x_q;
  assign y_px        = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on small timing (H 8/2/3/1, V 4/1/2/1),
// with an active-low and an active-high sync build side by side.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 1;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic px_en = 1'b0;

  logic hsync, vsync, av, ls, fs;
  logic [3:0] x, y;
  logic [1:0] fc;
  logic hsync2, vsync2, av2, ls2, fs2;
  logic [3:0] x2, y2;
  logic [1:0] fc2;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CW(4), .FW(2)
  ) dut (
    .clk(clk), .rst(rst), .px_en(px_en),
    .hsync(hsync), .vsync(vsync), .activevideo(av),
    .x_px(x), .y_px(y), .line_start(ls),
    .frame_start(fs), .frame_cnt(fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4), .FW(2)
  ) dut_hi (
    .clk(clk), .rst(rst), .px_en(px_en),
    .hsync(hsync2), .vsync(vsync2), .activevideo(av2),
    .x_px(x2), .y_px(y2), .line_start(ls2),
    .frame_start(fs2), .frame_cnt(fc2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       av;
    logic [3:0] x;
    logic [3:0] y;
    logic       ls;
    logic       fs;
    logic [1:0] fc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   mhc, mvc, mfc;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt_av, cnt_hs, cnt_ls, cnt_fs, cnt_vs;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one clk with the given inputs, update the model, push its
  // expectation, then compare after the edge.
  task automatic step(input logic en, input logic r);
    exp_t e;
    @(negedge clk);
    rst   = r;
    px_en = en;
    if (r) begin
      mhc = HT - 1; mvc = VT - 1; mfc = 3;
      cur = '{hs: 1'b1, vs: 1'b1, av: 1'b0, x: 4'd0, y: 4'd0,
              ls: 1'b0, fs: 1'b0, fc: 2'd3};
    end else if (en) begin
      if (mhc == HT - 1) begin
        mhc = 0;
        if (mvc == VT - 1) begin
          mvc = 0;
          mfc = (mfc + 1) % 4;
        end else mvc++;
      end else mhc++;
      cur.hs = !(mhc >= HA + HF && mhc < HA + HF + HS);
      cur.vs = !(mvc >= VA + VF && mvc < VA + VF + VS);
      cur.av = (mhc < HA) && (mvc < VA);
      cur.x  = cur.av ? 4'(mhc) : 4'd0;
      cur.y  = cur.av ? 4'(mvc) : 4'd0;
      cur.ls = (mhc == 0);
      cur.fs = (mhc == 0) && (mvc == 0);
      cur.fc = 2'(mfc);
    end else begin
      cur.ls = 1'b0;
      cur.fs = 1'b0;
    end
    sb.push_back(cur);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("hsync", int'(hsync), int'(e.hs));
    chk("vsync", int'(vsync), int'(e.vs));
    chk("active", int'(av), int'(e.av));
    chk("x_px", int'(x), int'(e.x));
    chk("y_px", int'(y), int'(e.y));
    chk("line_start", int'(ls), int'(e.ls));
    chk("frame_start", int'(fs), int'(e.fs));
    chk("frame_cnt", int'(fc), int'(e.fc));
    chk("hsync_hi", int'(hsync2), int'(!e.hs));
    chk("vsync_hi", int'(vsync2), int'(!e.vs));
    if (av) cnt_av++;
    if (!hsync) cnt_hs++;
    if (!vsync) cnt_vs++;
    if (ls) cnt_ls++;
    if (fs) cnt_fs++;
  endtask

  initial begin
    int guard;
    // reset held for a few clks
    repeat (3) step(1'b1, 1'b1);

    // first enabled edge wraps to (0,0)
    step(1'b1, 1'b0);
    chk("first_fs", int'(fs), 1);
    chk("first_fc", int'(fc), 0);
    step(1'b1, 1'b0);
    chk("second_fs", int'(fs), 0);

    // rest of the line plus the next line start
    cnt_av = 0; cnt_hs = 0; cnt_ls = 0;
    repeat (HT - 1) step(1'b1, 1'b0);
    chk("line_av_cnt", cnt_av, HA - 1);
    chk("line_hs_cnt", cnt_hs, HS);
    chk("line_ls_cnt", cnt_ls, 1);

    // five frames of free run
    cnt_vs = 0; cnt_fs = 0; cnt_ls = 0;
    repeat (5 * HT * VT) step(1'b1, 1'b0);
    chk("run_vs_cnt", cnt_vs, 5 * VS * HT);
    chk("run_fs_cnt", cnt_fs, 5);
    chk("run_ls_cnt", cnt_ls, 5 * VT);

    // px_en toggling, including holds at hc=0
    guard = 0;
    while (mhc != HT - 1 && guard < 200) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("seek_line_end", int'(guard < 200), 1);
    repeat (3) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end

    // reset mid-frame at (5,2)
    guard = 0;
    while (!(mhc == 5 && mvc == 2) && guard < 400) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("seek_5_2", int'(guard < 400), 1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("restart_fs", int'(fs), 1);
    chk("restart_fs_hi", int'(fs2), 1);
    repeat (20) step(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
